fetch: RTL and testbench
========================

# fetch

Instruction fetch stage of the dual-issue core, directly upstream of `decode`. It holds the fetch PC, drives the 64-bit-wide instruction memory (one upper + one lower 32-bit instruction per bundle, one PC per bundle), and registers each returned bundle with its PC into `pc`/`inst` for `decode`. It honours `decode`'s `interlock` stall and `branch_flag`/`branch_pc` redirect without losing, duplicating or reordering bundles.

## Interface
- `RESET_PC`, 32'h0: fetch PC after reset.
- `ADDR_W`, 15: instruction memory address width; `imem_addr = pc[ADDR_W-1:0]`.
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: synchronous, active-high reset.
- `interlock` in 1: decode stall; `pc`/`inst` must hold while high.
- `branch_flag` in 1: registered redirect from decode.
- `branch_pc` in 32: redirect target, valid with `branch_flag`.
- `imem_addr` out ADDR_W: read address, combinational.
- `imem_rdata` in 64: bundle at the address driven in the previous cycle (fixed 1-cycle BRAM latency).
- `pc` out 32: PC of the bundle presented to decode.
- `inst` out 64: bundle presented to decode; `{Nop,26'b0,Nop,26'b0}` when no valid bundle.
- `inst_valid` out 1: `inst` holds a real bundle (a bubble otherwise).

## Operation
- State: `fetch_pc` (32), `req_valid`/`req_pc` (read in flight), one-entry skid buffer `skid_valid`/`skid_pc`/`skid_inst`, output regs `pc`/`inst`/`inst_valid`.
- `issue = ~branch_flag & ~interlock & ~skid_valid`.
- `imem_addr` = `branch_pc[ADDR_W-1:0]` if `branch_flag`, else `fetch_pc[ADDR_W-1:0]`.
- Priority per edge: `rst` > `branch_flag` > `interlock` > normal.
- Reset: `fetch_pc`=RESET_PC; `req_valid`=0; `skid_valid`=0; `pc`=0; `inst`=NOP bundle; `inst_valid`=0. Reset mid-operation discards the in-flight read and the skid.
- Redirect (`branch_flag`=1): `fetch_pc` <= `branch_pc`+1; `req_valid` <= 1 with `req_pc` <= `branch_pc` (target read issued this cycle); `skid_valid` <= 0; outputs <= NOP bubble, `inst_valid` 0, `pc` 0. Applies even when `interlock`=1.
- Interlock (`interlock`=1, no branch): outputs hold. If `req_valid`, the returning `imem_rdata`/`req_pc` is written to the skid. `req_valid` <= 0 and `fetch_pc` holds.
- Normal (`interlock`=0, no branch): output source is skid if `skid_valid`, else `imem_rdata`/`req_pc` if `req_valid`, else NOP bubble. A consumed skid clears. `req_valid` <= `issue`; if issuing, `req_pc` <= `fetch_pc` and `fetch_pc` <= `fetch_pc`+1.
- At most one read is in flight, so one skid entry suffices. A skid overflow (`skid_valid` & `req_valid` & `interlock`) cannot occur; assert on it in simulation.
- `fetch_pc` wraps modulo 2^32; `imem_addr` truncates.

## Timing
- Address to `inst` latency is 2 cycles: the address is driven in cycle n, `imem_rdata` is valid in n+1, and the bundle appears on the outputs in n+2.
- First bundle (`pc`=RESET_PC) is on the outputs 2 cycles after the first cycle with `rst` low. Afterwards, one bundle per cycle with no stalls.
- `branch_flag` in cycle b gives a bubble in b+1 and the target bundle in b+2.
- Interlock released in cycle r: the skid bundle is output in r+1, and the next sequential read is issued in r+1, so there is one bubble in r+2 before r+3 resumes.

## Configuration
- `FETCH_STATS_EN` defined: adds outputs `stat_fetched`, `stat_stall` and `stat_flush` (32 bits each, wrap mod 2^32, reset to 0), counting:
  - bundles loaded with `inst_valid`=1;
  - cycles with `interlock`=1;
  - `branch_flag` cycles.
- `FETCH_STATS_EN` undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Straight line: imem[k]=`{k,~k}`, `rst` released in cycle 0 -> `pc`=0/`inst`=`{0,~0}` in cycle 2, `pc`=1 in cycle 3, `pc`=5 in cycle 7, `inst_valid`=1 throughout.
- Reset: `rst` held 3 cycles mid-stream at `pc`=9 -> NOP bundle, `inst_valid`=0, `pc`=0; restart from RESET_PC with the same 2-cycle latency.
- Interlock: `interlock`=1 for cycles 10-12 while showing `pc`=8 -> `pc` stays 8, then 9, bubble, 10, 11. Each PC is accepted exactly once by a model decode.
- Branch: `branch_flag`=1, `branch_pc`=0x40 in cycle b -> `imem_addr`=0x40 in b, bubble in b+1, `pc`=0x40 in b+2, 0x41 in b+3.
- Branch during interlock plus full skid -> skid is dropped; `pc`=`branch_pc` 2 cycles later; the stale PC never appears.
- `FETCH_STATS_EN`: 20 free cycles, 3 interlock cycles, 1 branch -> `stat_stall`=3, `stat_flush`=1, `stat_fetched` equals the model count.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-side bus: instruction memory read port plus the decode-facing
// bundle, stall and redirect signals.
`timescale 1ns/1ps
interface fetch_if #(
  parameter int ADDR_W = 15
);
  logic              interlock;
  logic              branch_flag;
  logic [31:0]       branch_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [63:0]       imem_rdata;
  logic [31:0]       pc;
  logic [63:0]       inst;
  logic              inst_valid;

  modport master (
    input  interlock, branch_flag, branch_pc, imem_rdata,
    output imem_addr, pc, inst, inst_valid
  );

  modport slave (
    output interlock, branch_flag, branch_pc, imem_rdata,
    input  imem_addr, pc, inst, inst_valid
  );
endinterface

// File: rtl/fetch.sv
// Dual-issue instruction fetch: PC, 1-cycle BRAM read, skid buffer, decode regs.
// Optional FETCH_STATS_EN adds fetched/stall/flush event counters.
`timescale 1ns/1ps
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          ADDR_W   = 15,
  parameter logic [5:0]  NOP_OP   = 6'h00
) (
  input  logic        clk,
  input  logic        rst,
  fetch_if.master     bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_stall,
  output logic [31:0] stat_flush
`endif
);

  localparam logic [63:0] NOP_BUNDLE = {NOP_OP, 26'b0, NOP_OP, 26'b0};

  logic [31:0] fetch_pc;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [63:0] skid_inst;
  logic        issue;
  logic        load_valid;

  assign issue      = ~bus.branch_flag & ~bus.interlock & ~skid_valid;
  assign load_valid = ~bus.branch_flag & ~bus.interlock & (skid_valid | req_valid);

  // Redirect target is read in the same cycle the branch is flagged.
  assign bus.imem_addr = bus.branch_flag ? bus.branch_pc[ADDR_W-1:0]
                                         : fetch_pc[ADDR_W-1:0];

  // Request stage -> BRAM -> decode output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc       <= RESET_PC;
      req_valid      <= 1'b0;
      skid_valid     <= 1'b0;
      bus.pc         <= 32'h0;
      bus.inst       <= NOP_BUNDLE;
      bus.inst_valid <= 1'b0;
    end else if (bus.branch_flag) begin
      fetch_pc       <= bus.branch_pc + 32'd1;
      req_valid      <= 1'b1;
      req_pc         <= bus.branch_pc;
      skid_valid     <= 1'b0;
      bus.pc         <= 32'h0;
      bus.inst       <= NOP_BUNDLE;
      bus.inst_valid <= 1'b0;
    end else if (bus.interlock) begin
      // The read already in flight lands in the skid instead of being lost.
      if (req_valid) begin
        skid_valid <= 1'b1;
        skid_pc    <= req_pc;
        skid_inst  <= bus.imem_rdata;
      end
      req_valid <= 1'b0;
    end else begin
      if (skid_valid) begin
        bus.pc     <= skid_pc;
        bus.inst   <= skid_inst;
        skid_valid <= 1'b0;
      end else if (req_valid) begin
        bus.pc     <= req_pc;
        bus.inst   <= bus.imem_rdata;
      end else begin
        bus.pc     <= 32'h0;
        bus.inst   <= NOP_BUNDLE;
      end
      bus.inst_valid <= load_valid;
      req_valid      <= issue;
      if (issue) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd1;
      end
    end
  end

  skid_overflow: assert property (@(posedge clk) disable iff (rst)
    !(skid_valid && req_valid && bus.interlock));

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetched <= 32'h0;
      stat_stall   <= 32'h0;
      stat_flush   <= 32'h0;
    end else begin
      if (load_valid)      stat_fetched <= stat_fetched + 32'd1;
      if (bus.interlock)   stat_stall   <= stat_stall + 32'd1;
      if (bus.branch_flag) stat_flush   <= stat_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: BRAM model, model decode with an expected-PC queue.
`timescale 1ns/1ps
module tb_fetch;
  localparam int          ADDR_W     = 15;
  localparam logic [31:0] RESET_PC   = 32'h0;
  localparam logic [5:0]  NOP_OP     = 6'h00;
  localparam logic [63:0] NOP_BUNDLE = {NOP_OP, 26'b0, NOP_OP, 26'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   n_acc = 0;
  logic [31:0] exp_q[$];

  fetch_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_stall, stat_flush;
`endif

  fetch #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W), .NOP_OP(NOP_OP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched(stat_fetched),
    .stat_stall(stat_stall),
    .stat_flush(stat_flush)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] bundle_of(input logic [31:0] k);
    return {k, ~k};
  endfunction

  // Instruction memory with fixed 1-cycle read latency.
  always @(posedge clk) bus.imem_rdata <= bundle_of(32'(bus.imem_addr));

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] p, input bit pc_chk);
    chk({tag, "_valid"}, 64'(bus.inst_valid), 64'(v));
    if (v) begin
      chk({tag, "_pc"}, 64'(bus.pc), 64'(p));
      chk({tag, "_inst"}, bus.inst, bundle_of(p));
    end else begin
      chk({tag, "_inst"}, bus.inst, NOP_BUNDLE);
      if (pc_chk) chk({tag, "_pc"}, 64'(bus.pc), 64'h0);
    end
  endtask

  task automatic chk_drained(input string tag);
    chk(tag, 64'(exp_q.size()), 64'h0);
  endtask

  // One cycle: drive this cycle's inputs, then let the model decode accept.
  task automatic tick(input logic r, input logic il, input logic bf, input logic [31:0] bpc);
    logic [31:0] e;
    @(posedge clk);
    #1;
    rst = r;
    bus.interlock = il;
    bus.branch_flag = bf;
    bus.branch_pc = bpc;
    #1;
    if (!r && !il && bus.inst_valid === 1'b1) begin
      n_acc++;
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_mis++;
        $error("FAIL sb_unexpected observed=pc %h expected=no bundle", bus.pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", 64'(bus.pc), 64'(e));
        chk("sb_inst", bus.inst, bundle_of(e));
      end
    end
  endtask

  initial begin
    bus.interlock = 1'b0;
    bus.branch_flag = 1'b0;
    bus.branch_pc = 32'h0;

    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("reset", 1'b0, 32'h0, 1'b1);

    // Straight line, then reset while pc=9 is showing
    for (int k = 0; k <= 8; k++) exp_q.push_back(32'(k));
    for (int c = 0; c <= 10; c++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      if (c == 0) chk("addr0", 64'(bus.imem_addr), 64'(RESET_PC[ADDR_W-1:0]));
      if (c < 2) chk_out("latency", 1'b0, 32'h0, 1'b1);
      else       chk_out("seq", 1'b1, 32'(c - 2), 1'b0);
    end
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("pc9", 1'b1, 32'd9, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("mid_reset_a", 1'b0, 32'h0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("mid_reset_b", 1'b0, 32'h0, 1'b1);
    chk_drained("drain_line");

    // Restart, interlock in cycles 10-12 while pc=8 is showing
    for (int k = 0; k <= 11; k++) exp_q.push_back(32'(k));
    for (int c = 0; c <= 17; c++) begin
      tick(1'b0, (c >= 10 && c <= 12), 1'b0, 32'h0);
      if (c < 2)        chk_out("restart", 1'b0, 32'h0, 1'b1);
      else if (c <= 9)  chk_out("seq2", 1'b1, 32'(c - 2), 1'b0);
      else if (c <= 13) chk_out("il_hold", 1'b1, 32'd8, 1'b0);
      else if (c == 14) chk_out("il_skid", 1'b1, 32'd9, 1'b0);
      else if (c == 15) chk_out("il_bubble", 1'b0, 32'h0, 1'b0);
      else              chk_out("il_resume", 1'b1, 32'(c - 6), 1'b0);
    end
    chk_drained("drain_il");

    // Branch to 0x40 while pc=12 is showing
    exp_q.push_back(32'd12);
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h41);
    exp_q.push_back(32'h42);
    tick(1'b0, 1'b0, 1'b1, 32'h40);
    chk("br_addr", 64'(bus.imem_addr), 64'h40);
    chk_out("br_b", 1'b1, 32'd12, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("br_bubble", 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("br_target", 1'b1, 32'h40, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("br_next", 1'b1, 32'h41, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("br_next2", 1'b1, 32'h42, 1'b0);
    chk_drained("drain_br");

    // Branch while interlocked with the skid full (pc 0x44 parked there)
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h101);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    chk_out("ilbr_hold", 1'b1, 32'h43, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 32'h100);
    chk_out("ilbr_hold2", 1'b1, 32'h43, 1'b0);
    chk("ilbr_addr", 64'(bus.imem_addr), 64'h100);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("ilbr_bubble", 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("ilbr_target", 1'b1, 32'h100, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("ilbr_next", 1'b1, 32'h101, 1'b0);
    chk_drained("drain_ilbr");

    // Mixed run for the event counters
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    n_acc = 0;
    for (int k = 0; k <= 17; k++) exp_q.push_back(32'(k));
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h201);
    exp_q.push_back(32'h202);
    for (int c = 0; c <= 27; c++) begin
      tick(1'b0, (c >= 10 && c <= 12), (c == 23), (c == 23) ? 32'h200 : 32'h0);
`ifdef FETCH_STATS_EN
      if (c == 0) begin
        chk("stat_fetched_rst", 64'(stat_fetched), 64'h0);
        chk("stat_stall_rst", 64'(stat_stall), 64'h0);
        chk("stat_flush_rst", 64'(stat_flush), 64'h0);
      end
`endif
      if (c == 25) chk_out("mix_target", 1'b1, 32'h200, 1'b0);
    end
    chk_drained("drain_mix");
`ifdef FETCH_STATS_EN
    chk("stat_stall", 64'(stat_stall), 64'd3);
    chk("stat_flush", 64'(stat_flush), 64'd1);
    chk("stat_fetched", 64'(stat_fetched), 64'(n_acc));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
